// File: rtl/text_mode_controller_if.sv
// Signal bundle between the text-mode controller, the VGA sync generator,
// the host write port and the font ROM.
interface text_mode_controller_if;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        video_on;
  logic        wr_valid;
  logic        wr_ready;
  logic [6:0]  wr_col;
  logic [5:0]  wr_row;
  logic [6:0]  wr_char;
  logic        clear_req;
  logic        busy;
  logic [6:0]  symbol_address;
  logic [2:0]  font_row;
  logic        font_video_on;
  logic [7:0]  symbol_line;
  logic        pixel_out;
  logic        pixel_valid;

  modport master (
    output pixel_x, pixel_y, video_on, wr_valid, wr_col, wr_row, wr_char,
           clear_req, symbol_line,
    input  wr_ready, busy, symbol_address, font_row, font_video_on,
           pixel_out, pixel_valid
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, wr_valid, wr_col, wr_row, wr_char,
           clear_req, symbol_line,
    output wr_ready, busy, symbol_address, font_row, font_video_on,
           pixel_out, pixel_valid
  );
endinterface

// File: rtl/text_mode_controller.sv
// 8x8 text-mode character buffer, glyph fetch pipeline and buffer clear engine.
// States: INIT | after reset, first clear write / CLEAR | fill buffer with BLANK_CHAR / IDLE | host writes allowed
module text_mode_controller #(
  parameter int         COLS           = 80,
  parameter int         ROWS           = 60,
  parameter logic [6:0] BLANK_CHAR     = 7'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  text_mode_controller_if.slave bus
);

  localparam int         DEPTH     = COLS * ROWS;
  localparam logic [12:0] LAST_ADDR = 13'(DEPTH - 1);
  localparam logic [7:0] COLS_W    = 8'(COLS);
  localparam logic [7:0] ROWS_W    = 8'(ROWS);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CLEAR} state_t;

  // row*COLS + col as a shift-and-add over the set bits of COLS
  function automatic logic [12:0] cell_addr(input logic [7:0] row, input logic [7:0] col);
    logic [12:0] acc;
    acc = {5'd0, col};
    for (int i = 0; i < 8; i++) begin
      if (COLS_W[i]) acc = acc + ({5'd0, row} << i);
    end
    return acc;
  endfunction

  state_t      state_q, state_d;
  logic [12:0] clr_cnt_q, clr_cnt_d;
  logic        clr_we;

  logic [6:0]  mem [DEPTH];
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [6:0]  ram_wdata;
  logic        rd_en;

  logic [7:0]  disp_col, disp_row;
  logic        disp_in_range;
  logic [12:0] disp_addr;
  logic        host_in_range;
  logic [12:0] host_addr;
  logic        host_we;
  logic        busy;
  logic        wr_ready;

  logic [6:0]  sym_addr_q;
  logic [2:0]  font_row_q;
  logic [2:0]  vid_q;
  logic [1:0]  show_q;
  logic [2:0]  x3_d1_q, x3_d2_q;
  logic        pixel_out_q;

  assign disp_col      = bus.pixel_x[10:3];
  assign disp_row      = bus.pixel_y[10:3];
  assign disp_in_range = (disp_col < COLS_W) && (disp_row < ROWS_W);
  assign disp_addr     = cell_addr(disp_row, disp_col);

  assign host_in_range = ({1'b0, bus.wr_col} < COLS_W) && ({2'b0, bus.wr_row} < ROWS_W);
  assign host_addr     = cell_addr({2'b0, bus.wr_row}, {1'b0, bus.wr_col});

  assign busy     = (state_q != S_IDLE);
  assign wr_ready = !bus.video_on && !busy;
  // out-of-range writes complete the handshake but never reach the RAM
  assign host_we  = bus.wr_valid && wr_ready && host_in_range;
  assign rd_en    = bus.video_on && disp_in_range;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      S_INIT: begin
        clr_cnt_d = '0;
        if (CLEAR_ON_RESET) begin
          state_d = S_CLEAR;
          // INIT already counts as the first clear slot so the full clear is DEPTH cycles
          if (!bus.video_on) begin
            clr_we    = 1'b1;
            clr_cnt_d = 13'd1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.clear_req) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        if (!bus.video_on) begin
          clr_we = 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            state_d   = S_IDLE;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 13'd1;
          end
        end
      end
      default: begin
        state_d   = S_INIT;
        clr_cnt_d = '0;
      end
    endcase
  end

  // single buffer port: display read, then clear write, then host write
  always_comb begin
    ram_addr  = disp_addr;
    ram_we    = 1'b0;
    ram_wdata = BLANK_CHAR;
    if (!bus.video_on) begin
      if (clr_we) begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt_q;
      end else if (host_we) begin
        ram_we    = 1'b1;
        ram_addr  = host_addr;
        ram_wdata = bus.wr_char;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sym_addr_q  <= '0;
      font_row_q  <= '0;
      vid_q       <= '0;
      show_q      <= '0;
      x3_d1_q     <= '0;
      x3_d2_q     <= '0;
      pixel_out_q <= 1'b0;
    end else begin
      sym_addr_q  <= rd_en ? mem[ram_addr] : 7'd0;
      font_row_q  <= bus.pixel_y[2:0];
      vid_q       <= {vid_q[1:0], bus.video_on};
      show_q      <= {show_q[0], rd_en};
      x3_d1_q     <= bus.pixel_x[2:0];
      x3_d2_q     <= x3_d1_q;
      pixel_out_q <= show_q[1] ? bus.symbol_line[3'd7 - x3_d2_q] : 1'b0;
    end
  end

  assign bus.wr_ready       = wr_ready;
  assign bus.busy           = busy;
  assign bus.symbol_address = sym_addr_q;
  assign bus.font_row       = font_row_q;
  assign bus.font_video_on  = vid_q[0];
  assign bus.pixel_out      = pixel_out_q;
  assign bus.pixel_valid    = vid_q[2];

endmodule

// File: tb/tb_text_mode_controller.sv
// Self-checking bench for text_mode_controller: buffer/pixel model, font ROM model,
// per-cycle output compare and directed scenarios with literal expectations.
module tb_text_mode_controller;
  localparam int         COLS  = 80;
  localparam int         ROWS  = 60;
  localparam int         DEPTH = COLS * ROWS;
  localparam logic [6:0] BLANK = 7'h20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  text_mode_controller_if tmc();

  text_mode_controller #(
    .COLS(COLS), .ROWS(ROWS), .BLANK_CHAR(BLANK), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (tmc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom(input logic [6:0] c, input logic [2:0] r);
    int v;
    v = (int'(c) * 29) ^ (int'(r) * 83) ^ 'hA5;
    return v[7:0];
  endfunction

  // registered font ROM
  always @(posedge clk) tmc.symbol_line <= rom(tmc.symbol_address, tmc.font_row);

  // ---------------- behavioural model ----------------
  logic [6:0] mbuf   [DEPTH];
  bit         mknown [DEPTH];
  bit         m_busy;
  int         m_pos;
  logic [6:0] m_sa;
  bit         m_sa_care;
  logic [2:0] m_fr;
  bit         m_fv;
  bit         m_pix [3];
  bit         m_pcare [3];
  bit         m_pv [3];

  int         mc_col, mc_row, mc_a, mc_wa;
  bit         mc_inr, mc_vo, mc_was_busy, mc_care, mc_p;
  logic [6:0] mc_ch;
  logic [7:0] mc_g;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b1; m_pos = 0;
      m_sa = '0; m_sa_care = 1'b1; m_fr = '0; m_fv = 1'b0;
      for (int i = 0; i < 3; i++) begin m_pix[i] = 0; m_pcare[i] = 1; m_pv[i] = 0; end
      for (int i = 0; i < DEPTH; i++) mknown[i] = 0;
    end else begin
      mc_vo  = tmc.video_on;
      mc_col = int'(tmc.pixel_x) / 8;
      mc_row = int'(tmc.pixel_y) / 8;
      mc_inr = (mc_col < COLS) && (mc_row < ROWS);
      mc_a   = mc_row * COLS + mc_col;
      mc_ch = '0; mc_care = 1'b1; mc_p = 1'b0;
      if (mc_vo && mc_inr) begin
        mc_ch   = mbuf[mc_a];
        mc_care = mknown[mc_a];
        mc_g    = rom(mc_ch, tmc.pixel_y[2:0]);
        mc_p    = mc_g[7 - int'(tmc.pixel_x[2:0])];
      end
      m_pix[2] = m_pix[1];   m_pix[1] = m_pix[0];   m_pix[0] = mc_p;
      m_pcare[2] = m_pcare[1]; m_pcare[1] = m_pcare[0]; m_pcare[0] = mc_care;
      m_pv[2] = m_pv[1];     m_pv[1] = m_pv[0];     m_pv[0] = mc_vo;
      m_sa = mc_ch; m_sa_care = mc_care; m_fr = tmc.pixel_y[2:0]; m_fv = mc_vo;
      mc_was_busy = m_busy;
      if (!mc_vo) begin
        if (m_busy) begin
          mbuf[m_pos] = BLANK; mknown[m_pos] = 1; m_pos++;
          if (m_pos == DEPTH) begin m_busy = 0; m_pos = 0; end
        end else if (tmc.wr_valid && int'(tmc.wr_col) < COLS && int'(tmc.wr_row) < ROWS) begin
          mc_wa = int'(tmc.wr_row) * COLS + int'(tmc.wr_col);
          mbuf[mc_wa] = tmc.wr_char; mknown[mc_wa] = 1;
        end
      end
      if (!mc_was_busy && tmc.clear_req) begin m_busy = 1; m_pos = 0; end
    end
  end

  // per-cycle compare
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", tmc.busy, m_busy);
      chk("wr_ready", tmc.wr_ready, !tmc.video_on && !m_busy);
      chk("font_video_on", tmc.font_video_on, m_fv);
      chk("pixel_valid", tmc.pixel_valid, m_pv[2]);
      if (m_fv) begin
        chk("font_row", tmc.font_row, m_fr);
        if (m_sa_care) chk("symbol_address", tmc.symbol_address, m_sa);
      end
      if (m_pv[2] && m_pcare[2]) chk("pixel_out", tmc.pixel_out, m_pix[2]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic read_cell(input int c, input int r, output logic [6:0] v);
    tmc.video_on = 1'b1;
    tmc.pixel_x  = 11'(c * 8);
    tmc.pixel_y  = 11'(r * 8);
    step();
    v = tmc.symbol_address;
    tmc.video_on = 1'b0;
  endtask

  // counts cycles spent clearing with video blanked until busy drops (or stop_at)
  task automatic clear_run(input bit alt, input int stop_at, output int n);
    n = 0;
    for (int c = 0; c < 30000; c++) begin
      tmc.clear_req = alt && (c == 300);
      if (alt) begin
        tmc.video_on = ((c / 10) % 2) == 0;
        tmc.pixel_x  = 11'(c % 656);
        tmc.pixel_y  = 11'((c / 656) % 8 + 8);
      end
      @(negedge clk);
      if (!tmc.busy) break;
      if (!tmc.video_on) n++;
      if (stop_at != 0 && n == stop_at) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    tmc.clear_req = 1'b0;
    tmc.video_on  = 1'b0;
  endtask

  int         n;
  logic [6:0] v;
  logic [7:0] seen;

  initial begin
    tmc.pixel_x = '0; tmc.pixel_y = '0; tmc.video_on = 1'b0;
    tmc.wr_valid = 1'b0; tmc.wr_col = '0; tmc.wr_row = '0; tmc.wr_char = '0;
    tmc.clear_req = 1'b0;
    #1 rst = 1'b1;
    step(); step();
    chk("rst_busy", tmc.busy, 1);
    chk("rst_symbol_address", tmc.symbol_address, 0);
    chk("rst_font_video_on", tmc.font_video_on, 0);
    chk("rst_pixel_valid", tmc.pixel_valid, 0);
    chk("rst_pixel_out", tmc.pixel_out, 0);
    rst = 1'b0;

    clear_run(1'b0, 0, n);
    chk("init_clear_len", n, 4800);
    read_cell(5, 7, v);
    chk("readback_blank", v, 7'h20);

    // host write then glyph row fetch
    tmc.wr_valid = 1'b1; tmc.wr_col = 7'd2; tmc.wr_row = 6'd1; tmc.wr_char = 7'h41;
    #1 chk("wr_ready_blank", tmc.wr_ready, 1);
    step();
    tmc.wr_valid = 1'b0;
    seen = '0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        tmc.video_on = 1'b1; tmc.pixel_x = 11'(16 + k); tmc.pixel_y = 11'd8;
      end else begin
        tmc.video_on = 1'b0;
      end
      step();
      if (k == 0) begin
        chk("glyph_symbol_address", tmc.symbol_address, 7'h41);
        chk("glyph_font_row", tmc.font_row, 0);
      end
      if (k >= 2) begin
        seen = {seen[6:0], tmc.pixel_out};
        chk("glyph_pixel_valid", tmc.pixel_valid, 1);
      end
    end
    chk("glyph_row_bits", seen, 8'hF8);

    // host write held across active video
    tmc.video_on = 1'b1; tmc.pixel_x = '0; tmc.pixel_y = '0;
    tmc.wr_valid = 1'b1; tmc.wr_col = 7'd3; tmc.wr_row = 6'd1; tmc.wr_char = 7'h42;
    #1 chk("wr_ready_active", tmc.wr_ready, 0);
    step(); step(); step();
    chk("wr_ready_held", tmc.wr_ready, 0);
    tmc.video_on = 1'b0;
    #1 chk("wr_ready_first_blank", tmc.wr_ready, 1);
    step();
    tmc.wr_valid = 1'b0;
    read_cell(3, 1, v);
    chk("readback_held_write", v, 7'h42);

    // out-of-range writes and pixels
    tmc.wr_valid = 1'b1; tmc.wr_col = 7'd80; tmc.wr_row = 6'd1; tmc.wr_char = 7'h55;
    #1 chk("oor_col_ready", tmc.wr_ready, 1);
    step();
    tmc.wr_col = 7'd5; tmc.wr_row = 6'd60; tmc.wr_char = 7'h56;
    #1 chk("oor_row_ready", tmc.wr_ready, 1);
    step();
    tmc.wr_valid = 1'b0;
    read_cell(0, 2, v);
    chk("oor_col_no_alias", v, 7'h20);
    read_cell(5, 59, v);
    chk("oor_row_no_alias", v, 7'h20);
    tmc.video_on = 1'b1; tmc.pixel_x = 11'd640; tmc.pixel_y = '0;
    step();
    chk("oor_symbol_address", tmc.symbol_address, 0);
    tmc.pixel_x = 11'd8; tmc.pixel_y = 11'd480;
    step(); step();
    chk("oor_pixel_out", tmc.pixel_out, 0);
    chk("oor_pixel_valid", tmc.pixel_valid, 1);
    tmc.video_on = 1'b0;
    step(); step(); step();

    // clear_req together with a host write, then clear interleaved with video
    tmc.wr_valid = 1'b1; tmc.wr_col = 7'd7; tmc.wr_row = 6'd0; tmc.wr_char = 7'h33;
    tmc.clear_req = 1'b1;
    #1 chk("clear_and_write_ready", tmc.wr_ready, 1);
    step();
    tmc.wr_valid = 1'b0; tmc.clear_req = 1'b0;
    chk("ready_after_clear_req", tmc.wr_ready, 0);
    clear_run(1'b1, 0, n);
    chk("frame_clear_len", n, 4800);
    read_cell(2, 1, v);
    chk("frame_clear_overwrote", v, 7'h20);

    // async reset in the middle of a clear
    tmc.clear_req = 1'b1;
    step();
    tmc.clear_req = 1'b0;
    clear_run(1'b0, 1000, n);
    tmc.video_on = 1'b1; tmc.pixel_x = 11'd5; tmc.pixel_y = 11'd3;
    step(); step(); step(); step();
    chk("pre_reset_valid", tmc.pixel_valid, 1);
    chk("pre_reset_pixel", tmc.pixel_out, 1);
    chk("pre_reset_font_row", tmc.font_row, 3);
    chk("pre_reset_symbol", tmc.symbol_address, 7'h20);
    #2 rst = 1'b1;
    #1;
    chk("arst_pixel_out", tmc.pixel_out, 0);
    chk("arst_pixel_valid", tmc.pixel_valid, 0);
    chk("arst_font_video_on", tmc.font_video_on, 0);
    chk("arst_symbol_address", tmc.symbol_address, 0);
    chk("arst_font_row", tmc.font_row, 0);
    chk("arst_busy", tmc.busy, 1);
    tmc.video_on = 1'b0;
    step(); step();
    rst = 1'b0;
    clear_run(1'b0, 0, n);
    chk("restart_clear_len", n, 4800);
    read_cell(3, 1, v);
    chk("post_restart_blank", v, 7'h20);
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/text_mode_controller.md
Name: text_mode_controller

Overview:
Sequences the glyph ROM for 8x8 text mode. It holds a COLS x ROWS character buffer and converts the current pixel_x/pixel_y into a character fetch, then into a glyph-row fetch, then into one serialized pixel bit. Host writes to the buffer and a buffer-clear engine share the buffer's single port with the display fetch. The block sits between the VGA sync generator and the colour output stage, with the font ROM as its datapath.

Parameters:
COLS, 80, text columns (glyph width 8 px)
ROWS, 60, text rows (glyph height 8 px)
BLANK_CHAR, 7'h20, code written by the clear engine
CLEAR_ON_RESET, 1, when 1, run a full clear after reset release

Ports:
clock  in  1  pixel clock
reset  in  1  asynchronous, active-high
pixel_x  in  11  current pixel column from sync generator
pixel_y  in  11  current pixel row from sync generator
video_on  in  1  active-area flag from sync generator
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted when wr_valid && wr_ready
wr_col  in  7  target column
wr_row  in  6  target row
wr_char  in  7  character code
clear_req  in  1  one-cycle pulse; fill buffer with BLANK_CHAR
busy  out  1  clear in progress
symbol_address  out  7  to font ROM: character code
font_row  out  3  to font ROM: glyph row (pixel_y[2:0], delayed)
font_video_on  out  1  to font ROM video_on, aligned with its output
symbol_line  in  8  from font ROM, valid 1 cycle after symbol_address/font_row
pixel_out  out  1  serialized glyph pixel
pixel_valid  out  1  video_on delayed to align with pixel_out

Behaviour:
- Buffer: COLS*ROWS x 7-bit single-port synchronous RAM, not reset. Address = row*COLS + col, 13 bits, computed without a multiplier (row<<6 + row<<4 + col for the defaults).
- Display pipeline. Fixed latency of 3 clocks from pixel_x/pixel_y to pixel_out.
  - C0: when video_on, read buffer at (pixel_y>>3, pixel_x>>3).
  - C1: symbol_address is registered from the RAM output. font_row is pixel_y[2:0] delayed 1. font_video_on is video_on delayed 1.
  - C2: the ROM registers symbol_line.
  - C3: pixel_out <= symbol_line[7 - x3], where x3 is pixel_x[2:0] delayed 2. pixel_valid is video_on delayed 3.
- Out-of-range pixel (col >= COLS or row >= ROWS) while video_on: symbol_address = 0 and pixel_out = 0.
- Port arbitration, per cycle, in priority order:
  1. Display read, when video_on.
  2. Clear engine write.
  3. Host write.
- wr_ready = !video_on && !busy. It is combinational and holds no state.
- A host write with col >= COLS or row >= ROWS is accepted (handshake completes) and dropped.
- FSM states:
  - INIT: entered on reset. Goes to CLEAR if CLEAR_ON_RESET, otherwise to IDLE on the first clock.
  - IDLE: clear_req goes to CLEAR with the clear counter at 0.
  - CLEAR: each cycle with !video_on, write BLANK_CHAR at the counter and increment it. After address COLS*ROWS-1 is written, go to IDLE. The counter holds while video_on.
- busy = 1 in INIT and CLEAR.
- clear_req while in CLEAR: ignored, no restart.
- clear_req and wr_valid in the same IDLE cycle: clear wins. wr_ready is 0 from the next cycle. The host write in that same cycle is still accepted if wr_ready was 1.
- Asynchronous reset, including mid-clear or mid-frame:
  - All pipeline registers clear: symbol_address = 0, font_row = 0, font_video_on = 0, pixel_out = 0, pixel_valid = 0.
  - FSM goes to INIT and busy = 1. The clear counter goes to 0.
  - Buffer contents are undefined unless re-cleared.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, video_on=0 -> busy high for exactly 4800 cycles, then 0. A readback of any cell gives 7'h20.
- During blanking, write char 7'h41 at (col 2, row 1); then drive pixel_x=16..23, pixel_y=8 with video_on=1 -> symbol_address=7'h41 and font_row=0 after 1 cycle. pixel_out equals ROM row bits 7..0 in order, starting 3 cycles after pixel_x=16.
- wr_valid held while video_on=1 -> wr_ready=0 and buffer unchanged. Drop video_on -> accepted in the first blanking cycle.
- clear_req mid-frame, alternating 10 active / 10 blanking cycles -> clear advances only in blanking cycles. busy deasserts after 4800 blanking cycles. Display reads are uncorrupted throughout.
- Write to col 80 / row 60 -> handshake completes and no cell changes. pixel_x=640 with video_on=1 -> pixel_out=0.
- Assert reset mid-CLEAR at counter 1000 -> all outputs 0 immediately (asynchronously). After release, the clear restarts from address 0.
